i2c_adc_target: RTL

//  I2C target (responder) emulating the ADS1115 register interface at a 7-bit address: pointer register

---
 rtl/i2c_adc_target.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_adc_target.sv
// rtl/i2c_adc_target.sv - I2C target presenting the ADS1115 pointer + four 16-bit register map
module i2c_adc_target #(
    parameter logic [6:0]  ADDRESS      = 7'h48,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [15:0] CONFIG_RESET = 16'h8583
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe_o,
    input  logic [15:0] conv_data_i,
    input  logic        conv_valid_i,
    output logic [15:0] config_o,
    output logic        config_wr_o,
    output logic        busy_o
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_ADDR       = 4'd1;
    localparam logic [3:0] S_ADDR_ACK   = 4'd2;
    localparam logic [3:0] S_PTR        = 4'd3;
    localparam logic [3:0] S_PTR_ACK    = 4'd4;
    localparam logic [3:0] S_WR_MSB     = 4'd5;
    localparam logic [3:0] S_WR_MSB_ACK = 4'd6;
    localparam logic [3:0] S_WR_LSB     = 4'd7;
    localparam logic [3:0] S_WR_LSB_ACK = 4'd8;
    localparam logic [3:0] S_RD_MSB     = 4'd9;
    localparam logic [3:0] S_RD_MSB_ACK = 4'd10;
    localparam logic [3:0] S_RD_LSB     = 4'd11;
    localparam logic [3:0] S_RD_LSB_ACK = 4'd12;
    localparam logic [3:0] S_IGNORE     = 4'd13;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_d, sda_d;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    logic [3:0]  state;
    logic [2:0]  bit_cnt;
    logic [6:0]  shreg;
    logic [7:0]  byte_in;
    logic        byte_done;
    logic        phase;
    logic        rw;
    logic [1:0]  pointer;
    logic [7:0]  wr_msb;
    logic [15:0] tx;
    logic [15:0] reg_conv, reg_lo, reg_hi;
    logic [15:0] rd_word;
    logic [3:0]  ack_next;

    // Bus idles high, so the synchronisers reset to 1 to avoid phantom edges.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;
    assign byte_in   = {shreg, sda_s};
    assign byte_done = scl_rise && (bit_cnt == 3'd7);

    always_comb begin
        rd_word = reg_conv;
        case (pointer)
            2'd1:    rd_word = config_o;
            2'd2:    rd_word = reg_lo;
            2'd3:    rd_word = reg_hi;
            default: rd_word = reg_conv;
        endcase
    end

    always_comb begin
        ack_next = S_WR_MSB;
        case (state)
            S_ADDR_ACK:   ack_next = S_PTR;
            S_PTR_ACK:    ack_next = S_WR_MSB;
            S_WR_MSB_ACK: ack_next = S_WR_LSB;
            default:      ack_next = S_WR_MSB;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            bit_cnt     <= 3'd0;
            shreg       <= 7'd0;
            phase       <= 1'b0;
            rw          <= 1'b0;
            pointer     <= 2'd0;
            wr_msb      <= 8'd0;
            tx          <= 16'd0;
            reg_conv    <= 16'd0;
            config_o    <= CONFIG_RESET;
            reg_lo      <= 16'h8000;
            reg_hi      <= 16'h7FFF;
            sda_oe_o    <= 1'b0;
            config_wr_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            config_wr_o <= 1'b0;
            if (conv_valid_i) reg_conv <= conv_data_i;

            if (start_det) begin
                state    <= S_ADDR;
                bit_cnt  <= 3'd0;
                sda_oe_o <= 1'b0;
            end else if (stop_det) begin
                state    <= S_IDLE;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
            end else begin
                if (scl_rise) begin
                    shreg   <= byte_in[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                case (state)
                    S_ADDR: if (byte_done) begin
                        if (byte_in[7:1] == ADDRESS) begin
                            state  <= S_ADDR_ACK;
                            phase  <= 1'b0;
                            busy_o <= 1'b1;
                            rw     <= byte_in[0];
                            tx     <= rd_word;
                        end else begin
                            state  <= S_IGNORE;
                            busy_o <= 1'b0;
                        end
                    end
                    // Target ACK slot: first fall pulls low, second fall ends the slot.
                    S_ADDR_ACK, S_PTR_ACK, S_WR_MSB_ACK, S_WR_LSB_ACK: if (scl_fall) begin
                        if (!phase) begin
                            sda_oe_o <= 1'b1;
                            phase    <= 1'b1;
                        end else begin
                            bit_cnt <= 3'd0;
                            phase   <= 1'b0;
                            if (state == S_ADDR_ACK && rw) begin
                                state    <= S_RD_MSB;
                                sda_oe_o <= ~tx[15];
                                tx       <= {tx[14:0], 1'b0};
                            end else begin
                                state    <= ack_next;
                                sda_oe_o <= 1'b0;
                            end
                        end
                    end
                    S_PTR: if (byte_done) begin
                        pointer <= byte_in[1:0];
                        state   <= S_PTR_ACK;
                        phase   <= 1'b0;
                    end
                    S_WR_MSB: if (byte_done) begin
                        wr_msb <= byte_in;
                        state  <= S_WR_MSB_ACK;
                        phase  <= 1'b0;
                    end
                    S_WR_LSB: if (byte_done) begin
                        case (pointer)
                            2'd1: begin
                                config_o    <= {wr_msb, byte_in};
                                config_wr_o <= 1'b1;
                            end
                            2'd2:    reg_lo <= {wr_msb, byte_in};
                            2'd3:    reg_hi <= {wr_msb, byte_in};
                            default: ;
                        endcase
                        state <= S_WR_LSB_ACK;
                        phase <= 1'b0;
                    end
                    S_RD_MSB, S_RD_LSB: begin
                        if (byte_done) begin
                            state <= (state == S_RD_MSB) ? S_RD_MSB_ACK : S_RD_LSB_ACK;
                            phase <= 1'b0;
                        end else if (scl_fall) begin
                            sda_oe_o <= ~tx[15];
                            tx       <= {tx[14:0], 1'b0};
                        end
                    end
                    // Master ACK slot: release on first fall, sample on rise, continue on next fall.
                    S_RD_MSB_ACK, S_RD_LSB_ACK: begin
                        if (scl_rise && !phase) begin
                            if (sda_s) begin
                                state  <= S_IGNORE;
                                busy_o <= 1'b0;
                            end else begin
                                phase <= 1'b1;
                                if (state == S_RD_LSB_ACK) tx <= rd_word;
                            end
                        end else if (scl_fall) begin
                            if (!phase) begin
                                sda_oe_o <= 1'b0;
                            end else begin
                                sda_oe_o <= ~tx[15];
                                tx       <= {tx[14:0], 1'b0};
                                bit_cnt  <= 3'd0;
                                phase    <= 1'b0;
                                state    <= (state == S_RD_MSB_ACK) ? S_RD_LSB : S_RD_MSB;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
